// File: rtl/tlp_tx_serializer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tlp_tx_serializer_if                                            |
// | Purpose  : Parallel TLP field bus plus the 32-bit DW link with SOP/EOP     |
// |            framing, shared by the serializer and its neighbours.           |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface tlp_tx_serializer_if #(
    parameter int MAX_PLD_DW = 32
);
    logic                      tlp_valid_i;
    logic                      tlp_ready_o;
    logic [2:0]                header_fmt_i;
    logic [4:0]                header_type_i;
    logic [2:0]                header_tc_i;
    logic [8:0]                header_length_i;
    logic [15:0]               header_requestID_i;
    logic [15:0]               header_completID_i;
    logic [32*MAX_PLD_DW-1:0]  data_i;
    logic [31:0]               addr_i;
    logic                      dw_valid_o;
    logic                      dw_ready_i;
    logic [31:0]               dw_data_o;
    logic                      sop_o;
    logic                      eop_o;
    logic                      err_o;
    logic [15:0]               pkt_cnt_o;

    // Serializer side
    modport slave (
        input  tlp_valid_i, header_fmt_i, header_type_i, header_tc_i,
               header_length_i, header_requestID_i, header_completID_i,
               data_i, addr_i, dw_ready_i,
        output tlp_ready_o, dw_valid_o, dw_data_o, sop_o, eop_o, err_o, pkt_cnt_o
    );

    // Request-block / link-sink side
    modport master (
        output tlp_valid_i, header_fmt_i, header_type_i, header_tc_i,
               header_length_i, header_requestID_i, header_completID_i,
               data_i, addr_i, dw_ready_i,
        input  tlp_ready_o, dw_valid_o, dw_data_o, sop_o, eop_o, err_o, pkt_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/tlp_tx_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tlp_tx_serializer                                               |
// | Purpose  : Builds a 3DW/4DW request or completion header from latched TLP  |
// |            fields, appends payload DWs and streams one DW per cycle.       |
// |            Owns the tag counter, packet counter and malformed-length drop. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tlp_tx_serializer #(
    parameter int MAX_PLD_DW = 32,
    parameter int TAG_W      = 8
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    tlp_tx_serializer_if.slave     bus
);
    localparam int         PIDX_W   = (MAX_PLD_DW > 1) ? $clog2(MAX_PLD_DW) : 1;
    localparam logic [8:0] MAX_LEN  = 9'(MAX_PLD_DW);
    localparam logic [4:0] TYPE_CPL = 5'b01010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PLD  = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;

    logic [2:0]                r_fmt;
    logic [4:0]                r_type;
    logic [2:0]                r_tc;
    logic [8:0]                r_len;
    logic [15:0]               r_req_id;
    logic [15:0]               r_cpl_id;
    logic [32*MAX_PLD_DW-1:0]  r_data;
    logic [31:0]               r_addr;
    logic [1:0]                r_hdr_idx;
    logic [PIDX_W-1:0]         r_pld_idx;
    logic [TAG_W-1:0]          r_tag;
    logic [15:0]               r_pkt_cnt;
    logic                      r_err;

    logic        w_is_cpl, w_no_pld, w_last_hdr, w_last_pld;
    logic        w_in_hdr, w_in_pld, w_xfer, w_eop_xfer, w_accept, w_malformed;
    logic [8:0]  w_pld_len;
    logic [1:0]  w_hdr_last_idx;
    logic [3:0]  w_last_be;
    logic [7:0]  w_tag_hdr;
    logic [11:0] w_byte_cnt;
    logic [31:0] w_addr_dw;
    logic [31:0] w_hdr_dw;
    logic [31:0] w_pld_dw;

    // Packet geometry from latched fields; completions are always 3DW
    assign w_is_cpl       = (r_type == TYPE_CPL);
    assign w_pld_len      = r_fmt[1] ? r_len : 9'd0;
    assign w_no_pld       = (w_pld_len == 9'd0);
    assign w_hdr_last_idx = (r_fmt[0] && !w_is_cpl) ? 2'd3 : 2'd2;
    assign w_last_hdr     = (r_hdr_idx == w_hdr_last_idx);
    assign w_last_pld     = ({{(9-PIDX_W){1'b0}}, r_pld_idx} == (w_pld_len - 9'd1));
    assign w_last_be      = (w_pld_len > 9'd1) ? 4'hF : 4'h0;
    assign w_tag_hdr      = 8'(r_tag);
    assign w_byte_cnt     = {1'b0, r_len, 2'b00};
    assign w_addr_dw      = {r_addr[31:2], 2'b00};
    assign w_pld_dw       = r_data[{r_pld_idx, 5'b00000} +: 32];

    // Header DW selected by header index
    always_comb begin
        w_hdr_dw = 32'h0;
        case (r_hdr_idx)
            2'd0: w_hdr_dw = {r_fmt, r_type, 1'b0, r_tc, 4'b0, 6'b0, 1'b0, r_len};
            2'd1: w_hdr_dw = w_is_cpl ? {r_cpl_id, 3'b000, 1'b0, w_byte_cnt}
                                      : {r_req_id, w_tag_hdr, w_last_be, 4'hF};
            2'd2: w_hdr_dw = w_is_cpl ? {r_req_id, w_tag_hdr, 1'b0, r_addr[6:0]}
                                      : (r_fmt[0] ? 32'h0 : w_addr_dw);
            default: w_hdr_dw = w_addr_dw;
        endcase
    end

    // Link outputs decode straight from state so they hold while stalled
    assign w_in_hdr       = (r_state == HDR);
    assign w_in_pld       = (r_state == PLD);
    assign bus.dw_valid_o = w_in_hdr | w_in_pld;
    assign bus.sop_o      = w_in_hdr && (r_hdr_idx == 2'd0);
    assign bus.eop_o      = (w_in_hdr && w_last_hdr && w_no_pld) || (w_in_pld && w_last_pld);
    assign bus.dw_data_o  = w_in_hdr ? w_hdr_dw : (w_in_pld ? w_pld_dw : 32'h0);

    // Handshakes; a new TLP may be taken in the same cycle the previous EOP leaves
    assign w_xfer          = bus.dw_valid_o & bus.dw_ready_i;
    assign w_eop_xfer      = w_xfer & bus.eop_o;
    assign bus.tlp_ready_o = (r_state == IDLE) | w_eop_xfer;
    assign w_accept        = bus.tlp_valid_i & bus.tlp_ready_o;
    assign w_malformed     = bus.header_fmt_i[1] &&
                             ((bus.header_length_i == 9'd0) || (bus.header_length_i > MAX_LEN));
    assign bus.err_o       = r_err;
    assign bus.pkt_cnt_o   = r_pkt_cnt;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state: header -> payload (if any); EOP returns to IDLE or straight to a new header
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept && !w_malformed) w_state_nxt = HDR;
            HDR:     if (w_xfer && w_last_hdr && !w_no_pld) w_state_nxt = PLD;
            PLD:     w_state_nxt = PLD;
            default: w_state_nxt = IDLE;
        endcase
        if (w_eop_xfer) w_state_nxt = (w_accept && !w_malformed) ? HDR : IDLE;
    end

    // Field capture on acceptance and DW index stepping on each transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fmt <= '0; r_type <= '0; r_tc <= '0; r_len <= '0;
            r_req_id <= '0; r_cpl_id <= '0; r_data <= '0; r_addr <= '0;
            r_hdr_idx <= '0; r_pld_idx <= '0;
        end else if (w_accept) begin
            r_fmt     <= bus.header_fmt_i;
            r_type    <= bus.header_type_i;
            r_tc      <= bus.header_tc_i;
            r_len     <= bus.header_length_i;
            r_req_id  <= bus.header_requestID_i;
            r_cpl_id  <= bus.header_completID_i;
            r_data    <= bus.data_i;
            r_addr    <= bus.addr_i;
            r_hdr_idx <= 2'd0;
            r_pld_idx <= '0;
        end else if (w_xfer) begin
            if (w_in_hdr) r_hdr_idx <= r_hdr_idx + 2'd1;
            if (w_in_pld) r_pld_idx <= r_pld_idx + 1'b1;
        end
    end

    // Tag / packet counters advance on EOP; error pulse one cycle after a malformed accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag     <= '0;
            r_pkt_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            r_err <= w_accept & w_malformed;
            if (w_eop_xfer) begin
                r_tag     <= r_tag + 1'b1;
                r_pkt_cnt <= r_pkt_cnt + 16'd1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_tlp_tx_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_tlp_tx_serializer                                            |
// | Purpose  : Directed and randomized bench for tlp_tx_serializer with a      |
// |            list-building packet model and a link monitor.                  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_tlp_tx_serializer;
    localparam int MAXDW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tlp_tx_serializer_if #(.MAX_PLD_DW(MAXDW)) bus ();
    tlp_tx_serializer #(.MAX_PLD_DW(MAXDW), .TAG_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_pass = 0;
    int n_total = 0;

    // Link ready: manual level, or random backpressure
    bit rand_en = 1'b0;
    bit rand_rdy = 1'b1;
    bit man_rdy = 1'b1;
    assign bus.dw_ready_i = rand_en ? rand_rdy : man_rdy;
    always @(posedge clk) begin
        #1 rand_rdy = ($urandom_range(0, 3) != 0);
    end

    // Link monitor: records every transfer, counts err pulses, watches stall stability
    logic [31:0] rx_d[$];
    bit          rx_s[$];
    bit          rx_e[$];
    int          rx_c[$];
    int cyc = 0, err_seen = 0, hold_viol = 0, both_viol = 0;
    bit stall = 1'b0;
    logic [31:0] st_d;
    bit st_s, st_e;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall = 1'b0;
        end else begin
            if (bus.err_o) err_seen++;
            if (stall && (!bus.dw_valid_o || bus.dw_data_o !== st_d ||
                          bus.sop_o !== st_s || bus.eop_o !== st_e)) hold_viol++;
            if (bus.sop_o && bus.eop_o) both_viol++;
            if (bus.dw_valid_o && bus.dw_ready_i) begin
                rx_d.push_back(bus.dw_data_o);
                rx_s.push_back(bus.sop_o);
                rx_e.push_back(bus.eop_o);
                rx_c.push_back(cyc);
                stall = 1'b0;
            end else if (bus.dw_valid_o) begin
                stall = 1'b1;
                st_d = bus.dw_data_o; st_s = bus.sop_o; st_e = bus.eop_o;
            end else begin
                stall = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (got running, expected done)");
        $fatal(1, "watchdog");
    end

    // Current TLP fields and the model state
    logic [2:0]    f_fmt;
    logic [4:0]    f_type;
    logic [2:0]    f_tc;
    logic [8:0]    f_len;
    logic [15:0]   f_req, f_cpl;
    logic [1023:0] f_data;
    logic [31:0]   f_addr;
    logic [31:0]   exp_d[$];
    bit            exp_s[$];
    bit            exp_e[$];
    int mtag = 0;
    int mcnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic bit is_bad();
        return f_fmt[1] && (f_len == 0 || f_len > MAXDW);
    endfunction

    task automatic clear_exp();
        exp_d.delete(); exp_s.delete(); exp_e.delete();
    endtask

    // Appends the expected DW list of the current fields using tag mtag
    task automatic build();
        bit cpl;
        int p, n0, bc;
        cpl = (f_type == 5'b01010);
        p   = f_fmt[1] ? int'(f_len) : 0;
        bc  = (int'(f_len) * 4) % 4096;
        n0  = exp_d.size();
        exp_d.push_back({f_fmt, f_type, 1'b0, f_tc, 10'b0, 1'b0, f_len});
        if (cpl) begin
            exp_d.push_back({f_cpl, 4'b0000, 12'(bc)});
            exp_d.push_back({f_req, 8'(mtag), 1'b0, f_addr[6:0]});
        end else begin
            exp_d.push_back({f_req, 8'(mtag), (p > 1) ? 8'hFF : 8'h0F});
            if (f_fmt[0]) exp_d.push_back(32'h0);
            exp_d.push_back({f_addr[31:2], 2'b00});
        end
        for (int i = 0; i < p; i++) exp_d.push_back(f_data[32*i +: 32]);
        for (int i = n0; i < exp_d.size(); i++) begin
            exp_s.push_back(i == n0);
            exp_e.push_back(i == exp_d.size() - 1);
        end
    endtask

    task automatic drive_fields();
        bus.header_fmt_i       = f_fmt;
        bus.header_type_i      = f_type;
        bus.header_tc_i        = f_tc;
        bus.header_length_i    = f_len;
        bus.header_requestID_i = f_req;
        bus.header_completID_i = f_cpl;
        bus.data_i             = f_data;
        bus.addr_i             = f_addr;
    endtask

    // Presents the fields and returns 1 time unit after the accepting edge
    task automatic send(input bit hold);
        int k;
        drive_fields();
        bus.tlp_valid_i = 1'b1;
        k = 0;
        do begin @(negedge clk); k++; end while (!bus.tlp_ready_o && k < 300);
        chk("accept_timeout", 32'(bus.tlp_ready_o), 32'd1);
        @(posedge clk); #1;
        if (!hold) bus.tlp_valid_i = 1'b0;
    endtask

    task automatic wait_rx(input int n);
        int k;
        k = 0;
        while (rx_d.size() < n && k < 3000) begin @(posedge clk); k++; end
        #1;
        chk("rx_timeout", 32'(rx_d.size() >= n), 32'd1);
    endtask

    task automatic check_pkt(input int base, input string nm);
        chk({nm, "_len"}, 32'(rx_d.size() - base), 32'(exp_d.size()));
        for (int i = 0; i < exp_d.size() && base + i < rx_d.size(); i++) begin
            chk($sformatf("%s_dw%0d", nm, i), rx_d[base+i], exp_d[i]);
            chk($sformatf("%s_sop%0d", nm, i), 32'(rx_s[base+i]), 32'(exp_s[i]));
            chk($sformatf("%s_eop%0d", nm, i), 32'(rx_e[base+i]), 32'(exp_e[i]));
        end
    endtask

    task automatic set_default();
        f_fmt = 3'b010; f_type = 5'b0; f_tc = 3'b0; f_len = 9'd1;
        f_req = 16'h0001; f_cpl = 16'h0; f_data = '0; f_addr = 32'h0;
    endtask

    int base, e0, sz_a;
    int r;

    initial begin
        bus.tlp_valid_i = 1'b0;
        set_default();
        drive_fields();
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        chk("rst_valid", 32'(bus.dw_valid_o), 0);
        chk("rst_sop", 32'(bus.sop_o), 0);
        chk("rst_eop", 32'(bus.eop_o), 0);
        chk("rst_err", 32'(bus.err_o), 0);
        chk("rst_data", bus.dw_data_o, 32'h0);
        chk("rst_pktcnt", 32'(bus.pkt_cnt_o), 0);
        chk("rst_ready", 32'(bus.tlp_ready_o), 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Malformed length: dropped with an err pulse
        set_default(); f_len = 9'd33;
        e0 = err_seen; base = rx_d.size();
        send(1'b0);
        chk("mal_err_hi", 32'(bus.err_o), 1);
        chk("mal_novalid", 32'(bus.dw_valid_o), 0);
        @(posedge clk); #1;
        chk("mal_err_lo", 32'(bus.err_o), 0);
        @(posedge clk); #1;
        chk("mal_err_cnt", 32'(err_seen - e0), 1);
        chk("mal_no_tx", 32'(rx_d.size() - base), 0);
        chk("mal_pktcnt", 32'(bus.pkt_cnt_o), 0);

        // 3DW memory write, tag 0
        set_default(); f_len = 9'd2; f_addr = 32'h20;
        f_data[31:0] = 32'h01234567; f_data[63:32] = 32'h89ABCDEF;
        base = rx_d.size(); clear_exp(); build();
        send(1'b0);
        chk("mwr_latency_sop", 32'(bus.sop_o & bus.dw_valid_o), 1);
        wait_rx(base + 5);
        check_pkt(base, "mwr");
        chk("mwr_lit0", rx_d[base], 32'h40000002);
        chk("mwr_lit1", rx_d[base+1], 32'h000100FF);
        chk("mwr_lit2", rx_d[base+2], 32'h00000020);
        chk("mwr_lit3", rx_d[base+3], 32'h01234567);
        chk("mwr_lit4", rx_d[base+4], 32'h89ABCDEF);
        mtag = (mtag + 1) % 256; mcnt++;
        chk("mwr_pktcnt", 32'(bus.pkt_cnt_o), 32'd1);

        // 4DW memory read
        set_default(); f_fmt = 3'b001; f_len = 9'd1; f_addr = 32'h1004; f_req = 16'hABCD;
        base = rx_d.size(); clear_exp(); build();
        send(1'b0);
        wait_rx(base + 4);
        check_pkt(base, "mrd");
        chk("mrd_eop3", 32'(rx_e[base+3]), 1);
        chk("mrd_dw3", rx_d[base+3], 32'h00001004);
        chk("mrd_be", 32'(rx_d[base+1][7:0]), 32'h0F);
        mtag = (mtag + 1) % 256; mcnt++;

        // Backpressure on payload DW1
        set_default(); f_len = 9'd4; f_addr = 32'h400;
        for (int i = 0; i < 4; i++) f_data[32*i +: 32] = $urandom;
        base = rx_d.size(); clear_exp(); build();
        send(1'b0);
        r = 0;
        while (rx_d.size() < base + 4 && r < 100) begin @(posedge clk); #1; r++; end
        man_rdy = 1'b0;
        chk("bp_first", bus.dw_data_o, exp_d[4]);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_hold%0d", i), bus.dw_data_o, exp_d[4]);
        end
        man_rdy = 1'b1;
        wait_rx(base + 7);
        check_pkt(base, "bp");
        mtag = (mtag + 1) % 256; mcnt++;

        // Asynchronous reset in the middle of the payload
        set_default(); f_len = 9'd8;
        base = rx_d.size();
        send(1'b0);
        r = 0;
        while (rx_d.size() < base + 5 && r < 100) begin @(posedge clk); #1; r++; end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.dw_valid_o), 0);
        chk("arst_data", bus.dw_data_o, 32'h0);
        chk("arst_sop_eop", 32'({bus.sop_o, bus.eop_o}), 0);
        chk("arst_pktcnt", 32'(bus.pkt_cnt_o), 0);
        @(posedge clk); #2 rst_n = 1'b1;
        mtag = 0; mcnt = 0;
        @(posedge clk); #1;
        chk("arst_ready", 32'(bus.tlp_ready_o), 1);
        chk("arst_idle", 32'(bus.dw_valid_o), 0);

        // Back-to-back: valid held high across two TLPs
        set_default(); f_len = 9'd1; f_addr = 32'h40;
        base = rx_d.size(); clear_exp(); build();
        sz_a = exp_d.size();
        send(1'b1);
        f_fmt = 3'b000; f_len = 9'd0; f_addr = 32'h80; f_req = 16'h0002;
        mtag = (mtag + 1) % 256;
        build();
        send(1'b0);
        wait_rx(base + exp_d.size());
        check_pkt(base, "b2b");
        chk("b2b_gap", 32'(rx_c[base+sz_a] - rx_c[base+sz_a-1]), 32'd1);
        chk("b2b_tag0", 32'(rx_d[base+1][15:8]), 32'd0);
        chk("b2b_tag1", 32'(rx_d[base+sz_a+1][15:8]), 32'd1);
        mtag = (mtag + 1) % 256; mcnt += 2;
        chk("b2b_pktcnt", 32'(bus.pkt_cnt_o), 32'(mcnt));

        // Randomized TLPs under random backpressure
        rand_en = 1'b1;
        for (int it = 0; it < 40; it++) begin
            f_fmt  = 3'($urandom);
            f_type = ($urandom_range(0, 2) == 0) ? 5'b01010 : 5'($urandom);
            f_tc   = 3'($urandom);
            r = $urandom_range(0, 9);
            if (r == 0)      f_len = 9'($urandom_range(33, 511));
            else if (r == 1) f_len = 9'd0;
            else             f_len = 9'($urandom_range(1, 32));
            f_req = 16'($urandom); f_cpl = 16'($urandom); f_addr = $urandom;
            for (int i = 0; i < 32; i++) f_data[32*i +: 32] = $urandom;
            base = rx_d.size();
            if (is_bad()) begin
                e0 = err_seen;
                send(1'b0);
                repeat (2) @(posedge clk); #1;
                chk($sformatf("rnd%0d_err", it), 32'(err_seen - e0), 32'd1);
                chk($sformatf("rnd%0d_notx", it), 32'(rx_d.size() - base), 32'd0);
            end else begin
                clear_exp(); build();
                send(1'b0);
                wait_rx(base + exp_d.size());
                check_pkt(base, $sformatf("rnd%0d", it));
                mtag = (mtag + 1) % 256; mcnt++;
                chk($sformatf("rnd%0d_pktcnt", it), 32'(bus.pkt_cnt_o), 32'(mcnt));
            end
        end
        rand_en = 1'b0;

        chk("hold_stable", 32'(hold_viol), 32'd0);
        chk("sop_eop_excl", 32'(both_viol), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
